// File: rtl/udp_loopback_buf_if.sv
// UDP user-side bundle for the loopback buffer: rx strobes, tx handshake and statistics.
// Valid/ready rule: a byte moves on udp_rx_data_vld or, on tx, one cycle after each sampled udp_tx_req.
interface udp_loopback_buf_if #(
  parameter int SLOT_NW = 2,
  parameter int CNT_W   = 16
);
  logic               loop_en;
  logic               udp_rx_data_vld;
  logic [7:0]         udp_rx_data;
  logic               udp_rx_done;
  logic [15:0]        udp_rx_data_num;
  logic               tx_rdy;
  logic               udp_tx_req;
  logic               udp_tx_en;
  logic [15:0]        udp_tx_data_num;
  logic [7:0]         udp_tx_data;
  logic [SLOT_NW:0]   frame_cnt;
  logic [CNT_W-1:0]   rx_ok_cnt;
  logic [CNT_W-1:0]   drop_cnt;
  logic [1:0]         rx_state_dbg;
  logic [1:0]         tx_state_dbg;

  modport master (
    output loop_en, udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
    output tx_rdy, udp_tx_req,
    input  udp_tx_en, udp_tx_data_num, udp_tx_data,
    input  frame_cnt, rx_ok_cnt, drop_cnt, rx_state_dbg, tx_state_dbg
  );

  modport slave (
    input  loop_en, udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
    input  tx_rdy, udp_tx_req,
    output udp_tx_en, udp_tx_data_num, udp_tx_data,
    output frame_cnt, rx_ok_cnt, drop_cnt, rx_state_dbg, tx_state_dbg
  );
endinterface

// File: rtl/udp_loopback_buf.sv
// Multi-slot UDP store-and-forward loopback: captures rx payloads into fixed slots and
// replays committed frames in arrival order through the UDP tx request handshake.
module udp_loopback_buf #(
  parameter int SLOT_AW  = 11,
  parameter int SLOT_NUM = 4,
  parameter int SLOT_NW  = 2,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  udp_loopback_buf_if.slave bus
);

  localparam int SLOT_DEPTH = 1 << SLOT_AW;
  localparam int LEN_W      = SLOT_AW + 1;
  localparam int MEM_AW     = SLOT_NW + SLOT_AW;

  typedef enum logic [1:0] {R_IDLE, R_WR, R_DROP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_SEND, T_END} tx_state_t;

  logic [7:0]         mem [SLOT_NUM*SLOT_DEPTH];
  logic [LEN_W-1:0]   len_q [SLOT_NUM];

  rx_state_t          rx_state_q, rx_state_d;
  logic [LEN_W-1:0]   wr_off_q, wr_off_d;
  logic [SLOT_NW-1:0] wr_ptr_q;
  logic [CNT_W-1:0]   rx_ok_q, drop_q;
  logic               byte_we_d;
  logic [SLOT_AW-1:0] byte_off_d;
  logic               rx_commit_d, rx_drop_d;
  logic               mem_we_q;
  logic [MEM_AW-1:0]  mem_waddr_q;
  logic [7:0]         mem_wdata_q;

  tx_state_t          tx_state_q;
  logic [SLOT_NW-1:0] rd_ptr_q;
  logic [LEN_W-1:0]   rd_off_q;
  logic [LEN_W-1:0]   tx_len_q;
  logic               tx_en_q;
  logic [15:0]        tx_num_q;
  logic               data_ok_q;
  logic [7:0]         ram_rd_q;
  logic               rd_fire_d, tx_release_d;

  logic [SLOT_NW:0]   frame_cnt_q;

  // A byte that arrives together with udp_rx_done is folded into the frame before the
  // done decision, so the length check sees the post-byte offset.
  always_comb begin
    rx_state_d  = rx_state_q;
    wr_off_d    = wr_off_q;
    byte_we_d   = 1'b0;
    byte_off_d  = wr_off_q[SLOT_AW-1:0];
    rx_commit_d = 1'b0;
    rx_drop_d   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (bus.udp_rx_data_vld) begin
          if (bus.loop_en && (frame_cnt_q < (SLOT_NW+1)'(SLOT_NUM))) begin
            byte_we_d  = 1'b1;
            byte_off_d = '0;
            wr_off_d   = LEN_W'(1);
            rx_state_d = R_WR;
          end else begin
            rx_state_d = R_DROP;
          end
        end
      end
      R_WR: begin
        if (bus.udp_rx_data_vld) begin
          if (wr_off_q == LEN_W'(SLOT_DEPTH)) begin
            rx_state_d = R_DROP;
          end else begin
            byte_we_d = 1'b1;
            wr_off_d  = wr_off_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (bus.udp_rx_done && (rx_state_d != R_IDLE)) begin
      if ((rx_state_d == R_WR) && (16'(wr_off_d) == bus.udp_rx_data_num)) begin
        rx_commit_d = 1'b1;
      end else begin
        rx_drop_d = 1'b1;
      end
      rx_state_d = R_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= R_IDLE;
      wr_off_q    <= '0;
      wr_ptr_q    <= '0;
      rx_ok_q     <= '0;
      drop_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < SLOT_NUM; i++) len_q[i] <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      wr_off_q    <= wr_off_d;
      mem_we_q    <= byte_we_d;
      mem_waddr_q <= {wr_ptr_q, byte_off_d};
      mem_wdata_q <= bus.udp_rx_data;
      if (rx_commit_d) begin
        len_q[wr_ptr_q] <= wr_off_d;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        rx_ok_q         <= rx_ok_q + 1'b1;
      end
      if (rx_drop_d) drop_q <= drop_q + 1'b1;
    end
  end

  // The write lands one cycle after the byte; tx cannot reach that slot within a cycle
  // of its commit, so the delay is invisible.
  always_ff @(posedge clk) begin
    if (mem_we_q) mem[mem_waddr_q] <= mem_wdata_q;
  end

  assign rd_fire_d    = bus.udp_tx_req && (tx_state_q == T_SEND) && (rd_off_q < tx_len_q);
  assign tx_release_d = (tx_state_q == T_END) && bus.tx_rdy;

  always_ff @(posedge clk) begin
    if (rd_fire_d) ram_rd_q <= mem[{rd_ptr_q, rd_off_q[SLOT_AW-1:0]}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= T_IDLE;
      rd_ptr_q   <= '0;
      rd_off_q   <= '0;
      tx_len_q   <= '0;
      tx_en_q    <= 1'b0;
      tx_num_q   <= '0;
      data_ok_q  <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      if (rd_fire_d) begin
        data_ok_q <= 1'b1;
      end else if (bus.udp_tx_req) begin
        data_ok_q <= 1'b0;
      end
      case (tx_state_q)
        T_IDLE: begin
          if ((frame_cnt_q != '0) && bus.tx_rdy) begin
            tx_len_q   <= len_q[rd_ptr_q];
            tx_num_q   <= 16'(len_q[rd_ptr_q]);
            tx_en_q    <= 1'b1;
            tx_state_q <= T_START;
          end
        end
        T_START: begin
          rd_off_q   <= '0;
          tx_state_q <= T_SEND;
        end
        T_SEND: begin
          if (rd_fire_d) begin
            rd_off_q <= rd_off_q + 1'b1;
            if ((rd_off_q + 1'b1) == tx_len_q) tx_state_q <= T_END;
          end
        end
        T_END: begin
          if (bus.tx_rdy) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            tx_state_q <= T_IDLE;
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  // Commit and release in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      case ({rx_commit_d, tx_release_d})
        2'b10:   frame_cnt_q <= frame_cnt_q + 1'b1;
        2'b01:   frame_cnt_q <= frame_cnt_q - 1'b1;
        default: frame_cnt_q <= frame_cnt_q;
      endcase
    end
  end

  assign bus.udp_tx_en       = tx_en_q;
  assign bus.udp_tx_data_num = tx_num_q;
  assign bus.udp_tx_data     = data_ok_q ? ram_rd_q : 8'h00;
  assign bus.frame_cnt       = frame_cnt_q;
  assign bus.rx_ok_cnt       = rx_ok_q;
  assign bus.drop_cnt        = drop_q;
  assign bus.rx_state_dbg    = rx_state_q;
  assign bus.tx_state_dbg    = tx_state_q;

endmodule

// File: tb/tb_udp_loopback_buf.sv
// Bench for udp_loopback_buf: randomized rx frames, a tx engine model, and a scoreboard
// whose expected bytes/lengths come from the frame-acceptance rules.
module tb_udp_loopback_buf;
  localparam int SLOT_AW  = 11;
  localparam int SLOT_NUM = 4;
  localparam int SLOT_NW  = 2;
  localparam int CNT_W    = 16;
  localparam int DEPTH    = 1 << SLOT_AW;
  localparam int E_IDLE = 0, E_BUSY = 1, E_GAP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_loopback_buf_if #(.SLOT_NW(SLOT_NW), .CNT_W(CNT_W)) bus ();

  udp_loopback_buf #(
    .SLOT_AW(SLOT_AW), .SLOT_NUM(SLOT_NUM), .SLOT_NW(SLOT_NW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int exp_len_q[$];
  int model_commits = 0, eng_done = 0, man_done = 0;
  int exp_ok = 0, exp_drop = 0, frames_seen = 0;

  bit manual = 1'b0, hold = 1'b0;
  logic man_req = 1'b0, man_rdy = 1'b0, eng_req = 1'b0, eng_rdy = 1'b0;
  int eng_st = E_IDLE;

  assign bus.udp_tx_req = manual ? man_req : eng_req;
  assign bus.tx_rdy     = manual ? man_rdy : eng_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected length on each frame start and one byte per in-frame request.
  initial begin : monitor
    int bytes_left;
    bit pend;
    logic [7:0] e;
    int l;
    bytes_left = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bytes_left = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (bytes_left > 0) begin
            chk("exp_byte_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("tx_data", 32'(bus.udp_tx_data), 32'(e));
            end
            bytes_left--;
          end else begin
            chk("tx_data_pad", 32'(bus.udp_tx_data), 32'd0);
          end
        end
        if (bus.udp_tx_en === 1'b1) begin
          chk("tx_en_expected", 32'(exp_len_q.size() != 0), 32'd1);
          if (exp_len_q.size() != 0) begin
            l = exp_len_q.pop_front();
            chk("tx_data_num", 32'(bus.udp_tx_data_num), 32'(l));
            bytes_left = l;
          end
          frames_seen++;
        end
        pend = (bus.udp_tx_req === 1'b1);
      end
    end
  end

  // Tx engine: on frame start drops tx_rdy, issues len plus a few surplus requests, then idles.
  initial begin : engine
    int left, gap;
    left = 0;
    gap = 0;
    forever begin
      tick();
      if (rst || manual) begin
        eng_st  = E_IDLE;
        eng_req = 1'b0;
        eng_rdy = !hold;
      end else begin
        case (eng_st)
          E_IDLE: begin
            eng_req = 1'b0;
            eng_rdy = !hold;
            if (bus.udp_tx_en === 1'b1) begin
              eng_rdy = 1'b0;
              left = int'(bus.udp_tx_data_num) + $urandom_range(0, 2);
              eng_st = E_BUSY;
            end
          end
          E_BUSY: begin
            eng_rdy = 1'b0;
            if (left > 0) begin
              eng_req = ($urandom_range(0, 3) != 0);
              if (eng_req) left--;
            end else begin
              eng_req = 1'b0;
              gap = $urandom_range(1, 3);
              eng_st = E_GAP;
            end
          end
          default: begin
            eng_req = 1'b0;
            if (gap > 0) gap--;
            else begin
              eng_rdy = !hold;
              eng_done++;
              eng_st = E_IDLE;
            end
          end
        endcase
      end
    end
  end

  task automatic rx_idle();
    bus.udp_rx_data_vld = 1'b0;
    bus.udp_rx_data     = 8'h00;
    bus.udp_rx_done     = 1'b0;
    bus.udp_rx_data_num = 16'h0000;
  endtask

  // Drives one frame and records the outcome the acceptance rules predict for it.
  task automatic rx_frame(input int len, input int num, input bit tog, input bit ramp,
                          input bit rdy_at_done);
    int occ;
    bit commit, merge;
    logic [7:0] b;
    occ = model_commits - eng_done - man_done;
    commit = (bus.loop_en === 1'b1) && (occ < SLOT_NUM) && (len <= DEPTH) && (num == len);
    merge = ($urandom_range(0, 1) == 1);
    if (commit) exp_len_q.push_back(len);
    for (int i = 0; i < len; i++) begin
      b = ramp ? 8'(i + 1) : 8'($urandom_range(0, 255));
      if (commit) exp_q.push_back(b);
      if (len <= 100 && $urandom_range(0, 3) == 0) begin
        tick();
        bus.udp_rx_data_vld = 1'b0;
        bus.udp_rx_data     = 8'h00;
      end
      tick();
      bus.udp_rx_data_vld = 1'b1;
      bus.udp_rx_data     = b;
      if (tog && i == len / 2) bus.loop_en = !bus.loop_en;
      if (merge && i == len - 1) begin
        bus.udp_rx_done     = 1'b1;
        bus.udp_rx_data_num = 16'(num);
        if (rdy_at_done) begin man_rdy = 1'b1; man_done++; end
      end
    end
    if (!merge) begin
      tick();
      bus.udp_rx_data_vld = 1'b0;
      bus.udp_rx_done     = 1'b1;
      bus.udp_rx_data_num = 16'(num);
      if (rdy_at_done) begin man_rdy = 1'b1; man_done++; end
    end
    tick();
    rx_idle();
    tick();
    if (commit) begin exp_ok++; model_commits++; end
    else exp_drop++;
  endtask

  task automatic wait_room();
    int n;
    n = 0;
    while ((model_commits - eng_done - man_done) >= SLOT_NUM && n < 20000) begin
      tick();
      n++;
    end
    chk("wait_room_timeout", 32'(n < 20000), 32'd1);
    tick();
    tick();
  endtask

  task automatic wait_tx_en();
    int n;
    n = 0;
    while (bus.udp_tx_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("tx_en_timeout", 32'(bus.udp_tx_en === 1'b1), 32'd1);
  endtask

  task automatic serve_manual(input int len);
    wait_tx_en();
    man_rdy = 1'b0;
    tick();
    for (int i = 0; i < len; i++) begin
      man_req = 1'b1;
      tick();
    end
    man_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 12000) begin
      @(negedge clk);
      done = (exp_len_q.size() == 0) && (exp_q.size() == 0) &&
             (bus.frame_cnt == '0) && (eng_st == E_IDLE);
      n++;
    end
    chk("drain_timeout", 32'(done), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    chk({tag, "_rx_ok"}, 32'(bus.rx_ok_cnt), 32'(exp_ok % (1 << CNT_W)));
    chk({tag, "_drop"},  32'(bus.drop_cnt),  32'(exp_drop % (1 << CNT_W)));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int seen0, len, num;
    rst = 1'b1;
    rx_idle();
    bus.loop_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_en",    32'(bus.udp_tx_en),       32'd0);
    chk("rst_tx_num",   32'(bus.udp_tx_data_num), 32'd0);
    chk("rst_tx_data",  32'(bus.udp_tx_data),     32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt),      32'd0);
    chk("rst_rx_ok",    32'(bus.rx_ok_cnt),       32'd0);
    chk("rst_drop",     32'(bus.drop_cnt),        32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Single ramp frame
    rx_frame(10, 10, 1'b0, 1'b1, 1'b0);
    drain();
    check_counters("single");

    // Queue full while the tx side is busy
    hold = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(8, 30);
      rx_frame(len, len, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("full_frame_cnt", 32'(bus.frame_cnt), 32'(SLOT_NUM));
    check_counters("full");
    hold = 1'b0;
    drain();

    // Overflow and length mismatch produce no transmission
    seen0 = frames_seen;
    rx_frame(DEPTH + 1, DEPTH + 1, 1'b0, 1'b0, 1'b0);
    rx_frame(20, 21, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    @(negedge clk);
    chk("bad_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("bad_no_tx", 32'(frames_seen - seen0), 32'd0);
    check_counters("bad");

    // Largest legal frame, then a zero-length done pulse
    rx_frame(DEPTH, DEPTH, 1'b0, 1'b0, 1'b0);
    drain();
    tick();
    bus.udp_rx_done = 1'b1;
    bus.udp_rx_data_num = 16'd0;
    tick();
    rx_idle();
    repeat (2) tick();
    check_counters("maxlen_zero");

    // loop_en off at start drops; toggling mid-frame keeps the frame
    bus.loop_en = 1'b0;
    rx_frame(64, 64, 1'b0, 1'b0, 1'b0);
    bus.loop_en = 1'b1;
    rx_frame(64, 64, 1'b1, 1'b0, 1'b0);
    bus.loop_en = 1'b1;
    drain();
    check_counters("loop_en");

    // Commit of B coincides with release of A
    manual = 1'b1;
    man_rdy = 1'b1;
    man_req = 1'b0;
    tick();
    rx_frame(6, 6, 1'b0, 1'b0, 1'b0);
    serve_manual(6);
    tick();
    @(negedge clk);
    chk("simul_before", 32'(bus.frame_cnt), 32'd1);
    rx_frame(5, 5, 1'b0, 1'b0, 1'b1);
    chk("simul_after", 32'(bus.frame_cnt), 32'd1);
    serve_manual(5);
    tick();
    man_rdy = 1'b1;
    man_done++;
    tick();
    manual = 1'b0;
    drain();
    check_counters("simul");

    // Randomized traffic long enough to wrap the slot pointers
    for (int k = 0; k < 14; k++) begin
      wait_room();
      bus.loop_en = ($urandom_range(0, 5) != 0);
      len = $urandom_range(1, 64);
      num = ($urandom_range(0, 7) == 0) ? len + 1 : len;
      rx_frame(len, num, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end
    bus.loop_en = 1'b1;
    drain();
    check_counters("random");

    // Reset in the middle of a transmission
    manual = 1'b1;
    man_rdy = 1'b1;
    man_req = 1'b0;
    tick();
    rx_frame(50, 50, 1'b0, 1'b0, 1'b0);
    serve_manual(3);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_en",    32'(bus.udp_tx_en),       32'd0);
    chk("midrst_tx_num",   32'(bus.udp_tx_data_num), 32'd0);
    chk("midrst_tx_data",  32'(bus.udp_tx_data),     32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt),      32'd0);
    chk("midrst_rx_ok",    32'(bus.rx_ok_cnt),       32'd0);
    exp_q.delete();
    exp_len_q.delete();
    exp_ok = 0;
    exp_drop = 0;
    man_done++;
    model_commits = eng_done + man_done;
    repeat (2) tick();
    rst = 1'b0;
    manual = 1'b0;
    repeat (3) tick();
    seen0 = frames_seen;
    rx_frame(8, 8, 1'b0, 1'b1, 1'b0);
    drain();
    chk("postrst_frames", 32'(frames_seen - seen0), 32'd1);
    check_counters("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_loopback_buf.md
Name: udp_loopback_buf

Overview:
- Multi-slot UDP frame store-and-forward buffer between the UDP user interface of the ethernet protocol block (udp_rx_* / udp_tx_* / tx_rdy) and itself.
- Captures received UDP payloads into SLOT_NUM fixed-size slots and replays each committed frame, in arrival order, through the UDP transmit handshake.
- Successor to the bare UDP wiring in the ethernet top: adds parametrised buffering, frame validation, drop accounting and a runtime loopback enable.

Parameters:
- SLOT_AW, 11, log2 of bytes per slot; SLOT_DEPTH = 2^SLOT_AW (2048).
- SLOT_NUM, 4, number of frame slots; power of two, 2..16.
- SLOT_NW, 2, log2(SLOT_NUM).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  single clock (GMII clock domain, rx and tx share it).
- rst  input  1  asynchronous active-high reset.
- loop_en  input  1  1 = capture and replay; 0 = discard new rx frames, finish the queue.
- udp_rx_data_vld  input  1  rx payload byte strobe.
- udp_rx_data  input  8  rx payload byte.
- udp_rx_done  input  1  one-cycle end-of-frame pulse.
- udp_rx_data_num  input  16  rx payload length, valid with udp_rx_done.
- tx_rdy  input  1  ethernet tx idle (1 = idle).
- udp_tx_req  input  1  per-byte data request from the tx engine.
- udp_tx_en  output  1  one-cycle frame start pulse.
- udp_tx_data_num  output  16  payload length, valid with udp_tx_en and held until the next start.
- udp_tx_data  output  8  tx byte, one cycle after udp_tx_req.
- frame_cnt  output  SLOT_NW+1  committed, unsent frames.
- rx_ok_cnt  output  CNT_W  frames committed (wraps).
- drop_cnt  output  CNT_W  frames dropped (wraps).

Behaviour:
- Reset values:
  - All outputs 0.
  - wr_ptr = rd_ptr = 0, frame_cnt = 0, both FSMs in IDLE.
  - Buffer RAM contents are not reset.
  - Reset asserted mid-frame aborts rx and tx immediately; the tx engine sees no further udp_tx_en.
- Storage:
  - One SLOT_NUM*SLOT_DEPTH x 8 RAM with synchronous read.
  - Address = {slot, offset}.
  - Per-slot length register, SLOT_AW+1 bits.
- RX FSM states: R_IDLE, R_WR, R_DROP.
  - R_IDLE, first vld byte: if loop_en=1 and frame_cnt<SLOT_NUM, write the byte at offset 0, wr_off=1, go to R_WR. Otherwise go to R_DROP.
  - R_WR, each vld byte: write at wr_off, then wr_off+1. A byte arriving with wr_off==SLOT_DEPTH sends the FSM to R_DROP (overflow).
  - R_WR, udp_rx_done:
    - If wr_off==udp_rx_data_num, commit: store the length, wr_ptr+1 (mod SLOT_NUM), rx_ok_cnt+1.
    - Otherwise drop (length mismatch).
    - Return to R_IDLE in both cases.
  - udp_rx_done together with a final vld byte counts that byte first.
  - R_DROP: on udp_rx_done, drop_cnt+1 and return to R_IDLE.
  - udp_rx_done in R_IDLE with no bytes (zero length) is ignored and not counted.
- TX FSM states: T_IDLE, T_START, T_SEND, T_END.
  - T_IDLE: when frame_cnt>0 and tx_rdy=1, load len(rd_ptr) and go to T_START.
  - T_START: udp_tx_en=1 for exactly one cycle, udp_tx_data_num={zero-extend len}, rd_off=0, go to T_SEND.
  - T_SEND:
    - Each udp_tx_req with rd_off<len: RAM read at {rd_ptr, rd_off}, rd_off+1. udp_tx_data is valid the next cycle (latency 1) and holds until the next read.
    - When rd_off reaches len, go to T_END.
    - Requests beyond len are ignored; udp_tx_data is forced to 0 for them.
  - T_END: when tx_rdy=1, free the slot (rd_ptr+1), go to T_IDLE. At least one cycle passes in T_END before tx_rdy is sampled.
  - Back-to-back frames: minimum 2 cycles from slot release to the next udp_tx_en.
- frame_cnt:
  - +1 on commit, -1 on release.
  - A commit and a release in the same cycle leave it unchanged.
  - Never exceeds SLOT_NUM and never underflows.
- loop_en falling mid-rx does not affect the frame in progress. It affects only frames that start afterwards. Queued frames still transmit.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Single frame: rx 10 bytes 0x01..0x0A, udp_rx_data_num=10, tx_rdy=1, tx engine returns 10 req pulses → one udp_tx_en with data_num=10; udp_tx_data=0x01..0x0A each one cycle after req; rx_ok_cnt=1, frame_cnt ends at 0.
- Queue full: tx_rdy held 0 and 5 frames received (SLOT_NUM=4) → frames 1–4 committed, frame 5 dropped; frame_cnt=4, drop_cnt=1. Release tx_rdy → 4 frames transmitted in order.
- Bad frames:
  - 2049-byte frame → overflow drop.
  - 20 bytes with udp_rx_data_num=21 → mismatch drop.
  - Result: drop_cnt=2, frame_cnt=0, no udp_tx_en.
- Simultaneous events: commit of frame B in the same cycle as release of frame A → frame_cnt unchanged. Wrap-around: 9 frames sent sequentially → wr_ptr/rd_ptr wrap; payloads intact.
- loop_en=0 during a 64-byte rx → the frame is dropped and drop_cnt increments. Toggling loop_en mid-frame does not cut off the frame already in progress.
- Reset mid-transmission (after 3 of 50 req) → all outputs 0 next cycle, frame_cnt=0; after reset, a new 8-byte frame loops back correctly.
